// File: rtl/m84_sample_player.sv
// m84_sample_player
//   M84 PCM sample stage behind the Z80 sound block.
//   - Holds the 16-bit sample ROM pointer. The pointer has byte loads and a
//     post-increment.
//   - Prefetches the ROM byte at the pointer from SDRAM so that the Z80 can
//     read it back on port 0x84.
//   - Low-passes the unsigned DAC byte written to port 0x82 into a signed
//     16-bit audio sample.
//
// Ports
//   CLK_32M        system clock
//   reset_n        asynchronous reset, active low
//   pause          freezes the filter divider/update and the issue of new fetches
//   sample_addr    pointer byte source
//   sample_addr_wr [0] loads ptr[7:0], [1] loads ptr[15:8]
//   sample_inc     1-cycle pulse: ptr+1 and latch sample_out as the DAC target
//   sample_out     unsigned DAC byte, 0x80 = silence
//   sample_in      last fetched ROM byte
//   sample_valid   sample_in corresponds to the current pointer
//   rom_req        SDRAM read request (level)
//   rom_addr       ROM_BASE + ptr, stable while rom_req is high
//   rom_ack        1-cycle pulse: rom_data valid, request complete
//   rom_data       SDRAM read data
//   dac_out        signed filtered DAC output
module m84_sample_player #(
  parameter int unsigned          ROM_AW     = 18,
  parameter logic [ROM_AW-1:0]    ROM_BASE   = '0,
  parameter int unsigned          FILT_SHIFT = 2,
  parameter int unsigned          FILT_DIV   = 572
) (
  input  logic              CLK_32M,
  input  logic              reset_n,
  input  logic              pause,
  input  logic [15:0]       sample_addr,
  input  logic [1:0]        sample_addr_wr,
  input  logic              sample_inc,
  input  logic [7:0]        sample_out,
  output logic [7:0]        sample_in,
  output logic              sample_valid,
  output logic              rom_req,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  output logic [15:0]       dac_out
);

  localparam int unsigned DIV_W = (FILT_DIV > 1) ? $clog2(FILT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FILT_DIV - 1);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } fetch_state_t;

  fetch_state_t      state;
  logic [15:0]       ptr;
  logic [15:0]       ptr_nxt;
  logic              ptr_chg;
  logic              dirty;
  logic              issue;
  logic [15:0]       target;
  logic [DIV_W-1:0]  div_cnt;
  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic [15:0]       dac_nxt;

  // Byte loads win over increment; any load or increment counts as a change.
  always_comb begin
    ptr_nxt = ptr;
    ptr_chg = 1'b0;
    if (|sample_addr_wr) begin
      if (sample_addr_wr[0]) ptr_nxt[7:0]  = sample_addr[7:0];
      if (sample_addr_wr[1]) ptr_nxt[15:8] = sample_addr[15:8];
      ptr_chg = 1'b1;
    end else if (sample_inc) begin
      ptr_nxt = ptr + 16'd1;
      ptr_chg = 1'b1;
    end
  end

  assign issue   = (state == S_IDLE) && dirty && !pause;
  assign rom_req = (state == S_REQ);

  // Pointer and fetch control
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      ptr          <= '0;
      state        <= S_IDLE;
      dirty        <= 1'b1;
      rom_addr     <= '0;
      sample_in    <= '0;
      sample_valid <= 1'b0;
    end else begin
      ptr <= ptr_nxt;

      case (state)
        S_IDLE: begin
          if (issue) begin
            state    <= S_REQ;
            rom_addr <= ROM_BASE + ROM_AW'(ptr);
          end
        end
        S_REQ: begin
          if (rom_ack) begin
            state <= S_IDLE;
            // Data is kept only if the pointer has not moved since issue,
            // including a move on this very edge.
            if (!dirty && !ptr_chg) begin
              sample_in    <= rom_data;
              sample_valid <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // A pointer change on the issue edge leaves dirty set, so the stale
      // request is discarded on ack and re-issued afterwards.
      if (ptr_chg) begin
        dirty        <= 1'b1;
        sample_valid <= 1'b0;
      end else if (issue) begin
        dirty <= 1'b0;
      end
    end
  end

  // One-pole low-pass: dac += (target - dac) >>> FILT_SHIFT
  always_comb begin
    diff    = $signed({target[15], target}) - $signed({dac_out[15], dac_out});
    step    = diff >>> FILT_SHIFT;
    dac_nxt = dac_out + step[15:0];
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      target  <= '0;
      div_cnt <= '0;
      dac_out <= '0;
    end else begin
      // Flip the MSB to turn offset-binary 0x80 silence into signed zero.
      if (sample_inc) target <= {~sample_out[7], sample_out[6:0], 8'h00};
      if (!pause) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          dac_out <= dac_nxt;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_m84_sample_player.sv
module tb_m84_sample_player;

  localparam int unsigned DIV = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        pause = 1'b0;

  // Instance A: FILT_SHIFT=0, ROM_BASE=0
  logic [15:0] addr_a = '0;
  logic [1:0]  wr_a = '0;
  logic        inc_a = 1'b0;
  logic [7:0]  sout_a = 8'h80;
  logic [7:0]  sin_a;
  logic        valid_a;
  logic        req_a;
  logic [17:0] raddr_a;
  logic        ack_a = 1'b0;
  logic [7:0]  rdata_a = '0;
  logic [15:0] dac_a;

  // Instance B: FILT_SHIFT=2, ROM_BASE=0x3F000, ROM side never acked
  logic        inc_b = 1'b0;
  logic [7:0]  sout_b = 8'h80;
  logic [7:0]  sin_b;
  logic        valid_b;
  logic        req_b;
  logic [17:0] raddr_b;
  logic [15:0] dac_b;

  int total = 0;
  int bad = 0;
  int bcnt = 0;

  always #5 clk = ~clk;

  // Reference divider position: the tick edge is the one where bcnt == DIV-1.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) bcnt <= 0;
    else if (!pause) bcnt <= (bcnt == DIV - 1) ? 0 : bcnt + 1;
  end

  m84_sample_player #(.ROM_AW(18), .ROM_BASE(18'h00000), .FILT_SHIFT(0), .FILT_DIV(DIV)) dut_a (
    .CLK_32M(clk), .reset_n(reset_n), .pause(pause),
    .sample_addr(addr_a), .sample_addr_wr(wr_a), .sample_inc(inc_a), .sample_out(sout_a),
    .sample_in(sin_a), .sample_valid(valid_a), .rom_req(req_a), .rom_addr(raddr_a),
    .rom_ack(ack_a), .rom_data(rdata_a), .dac_out(dac_a)
  );

  m84_sample_player #(.ROM_AW(18), .ROM_BASE(18'h3F000), .FILT_SHIFT(2), .FILT_DIV(DIV)) dut_b (
    .CLK_32M(clk), .reset_n(reset_n), .pause(pause),
    .sample_addr(16'h0000), .sample_addr_wr(2'b00), .sample_inc(inc_b), .sample_out(sout_b),
    .sample_in(sin_b), .sample_valid(valid_b), .rom_req(req_b), .rom_addr(raddr_b),
    .rom_ack(1'b0), .rom_data(8'h00), .dac_out(dac_b)
  );

  // Called at a negedge; returns at a negedge with req_a high, or got=0 on timeout.
  task automatic wait_req_a(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (req_a) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_ack_a(input logic [7:0] d);
    ack_a = 1'b1;
    rdata_a = d;
    @(negedge clk);
    ack_a = 1'b0;
    rdata_a = 8'h00;
  endtask

  // Returns at the negedge just after the next filter tick edge.
  task automatic wait_tick(output bit got);
    got = 1'b0;
    for (int i = 0; i < 2 * DIV + 2; i++) begin
      if (bcnt == DIV - 1 && !pause) begin
        @(negedge clk);
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bit got;
    #1 reset_n = 1'b0;
    #22;
    total++; if (req_a !== 1'b0) begin bad++; $display("FAIL reset_req_a: got %b want 0", req_a); end
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid_a: got %b want 0", valid_a); end
    total++; if (sin_a !== 8'h00) begin bad++; $display("FAIL reset_sin_a: got %h want 00", sin_a); end
    total++; if (dac_a !== 16'h0000 || dac_b !== 16'h0000) begin bad++; $display("FAIL reset_dac: got %h/%h want 0000/0000", dac_a, dac_b); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wait_req_a(got);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL reset_fetch: got no rom_req want rom_req=1"); end
    total++; if (raddr_a !== 18'h00000) begin bad++; $display("FAIL reset_addr_a: got %h want 00000", raddr_a); end
    total++; if (req_b !== 1'b1 || raddr_b !== 18'h3F000) begin bad++; $display("FAIL reset_addr_b: got req=%b addr=%h want 1/3f000", req_b, raddr_b); end
    pulse_ack_a(8'h5A);
    total++; if (sin_a !== 8'h5A || valid_a !== 1'b1 || req_a !== 1'b0) begin bad++; $display("FAIL reset_ack: got sin=%h v=%b req=%b want 5a/1/0", sin_a, valid_a, req_a); end
    // ack while idle must be ignored
    pulse_ack_a(8'hEE);
    total++; if (sin_a !== 8'h5A || valid_a !== 1'b1) begin bad++; $display("FAIL idle_ack: got sin=%h v=%b want 5a/1", sin_a, valid_a); end
  endtask

  task automatic test_load_fetch;
    bit got;
    addr_a = 16'h1234;
    wr_a = 2'b11;
    @(negedge clk);
    wr_a = 2'b00;
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL load_valid_drop: got %b want 0", valid_a); end
    wait_req_a(got);
    total++; if (got !== 1'b1 || raddr_a !== 18'h01234) begin bad++; $display("FAIL load_req: got req=%b addr=%h want 1/01234", got, raddr_a); end
    repeat (5) @(negedge clk);
    total++; if (req_a !== 1'b1 || raddr_a !== 18'h01234) begin bad++; $display("FAIL load_hold: got req=%b addr=%h want 1/01234", req_a, raddr_a); end
    pulse_ack_a(8'hA5);
    total++; if (sin_a !== 8'hA5 || valid_a !== 1'b1 || req_a !== 1'b0) begin bad++; $display("FAIL load_data: got sin=%h v=%b req=%b want a5/1/0", sin_a, valid_a, req_a); end
  endtask

  task automatic test_wrap;
    bit got;
    addr_a = 16'hFFFF;
    wr_a = 2'b11;
    @(negedge clk);
    wr_a = 2'b00;
    wait_req_a(got);
    total++; if (got !== 1'b1 || raddr_a !== 18'h0FFFF) begin bad++; $display("FAIL wrap_req_ffff: got req=%b addr=%h want 1/0ffff", got, raddr_a); end
    pulse_ack_a(8'h33);
    sout_a = 8'h80;
    inc_a = 1'b1;
    @(negedge clk);
    inc_a = 1'b0;
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL wrap_valid_drop: got %b want 0", valid_a); end
    wait_req_a(got);
    total++; if (got !== 1'b1 || raddr_a !== 18'h00000) begin bad++; $display("FAIL wrap_addr: got req=%b addr=%h want 1/00000", got, raddr_a); end
    pulse_ack_a(8'h44);
    total++; if (sin_a !== 8'h44 || valid_a !== 1'b1) begin bad++; $display("FAIL wrap_data: got sin=%h v=%b want 44/1", sin_a, valid_a); end
  endtask

  task automatic test_inc_midreq;
    bit got;
    addr_a = 16'h0100;
    wr_a = 2'b11;
    @(negedge clk);
    wr_a = 2'b00;
    wait_req_a(got);
    total++; if (got !== 1'b1 || raddr_a !== 18'h00100) begin bad++; $display("FAIL midreq_req: got req=%b addr=%h want 1/00100", got, raddr_a); end
    @(negedge clk);
    sout_a = 8'h80;
    inc_a = 1'b1;
    @(negedge clk);
    inc_a = 1'b0;
    total++; if (req_a !== 1'b1 || raddr_a !== 18'h00100) begin bad++; $display("FAIL midreq_hold: got req=%b addr=%h want 1/00100", req_a, raddr_a); end
    pulse_ack_a(8'h11);
    total++; if (sin_a !== 8'h44 || valid_a !== 1'b0 || req_a !== 1'b0) begin bad++; $display("FAIL midreq_discard: got sin=%h v=%b req=%b want 44/0/0", sin_a, valid_a, req_a); end
    @(negedge clk);
    total++; if (req_a !== 1'b1 || raddr_a !== 18'h00101) begin bad++; $display("FAIL midreq_reissue: got req=%b addr=%h want 1/00101", req_a, raddr_a); end
    pulse_ack_a(8'h22);
    total++; if (sin_a !== 8'h22 || valid_a !== 1'b1) begin bad++; $display("FAIL midreq_data: got sin=%h v=%b want 22/1", sin_a, valid_a); end
  endtask

  task automatic test_dac_noshift;
    bit got;
    logic [7:0]  vin [3];
    logic [15:0] vexp [3];
    vin  = '{8'hFF, 8'h80, 8'h00};
    vexp = '{16'h7F00, 16'h0000, 16'h8000};
    for (int i = 0; i < 3; i++) begin
      sout_a = vin[i];
      inc_a = 1'b1;
      @(negedge clk);
      inc_a = 1'b0;
      wait_tick(got);
      total++; if (got !== 1'b1 || dac_a !== vexp[i]) begin bad++; $display("FAIL dac_noshift[%0d]: got tick=%b dac=%h want 1/%h", i, got, dac_a, vexp[i]); end
    end
  endtask

  task automatic test_filter_pause;
    bit got;
    logic [15:0] vexp [3];
    vexp = '{16'h1000, 16'h1C00, 16'h2500};
    sout_b = 8'hC0;
    inc_b = 1'b1;
    @(negedge clk);
    inc_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_tick(got);
      total++; if (got !== 1'b1 || dac_b !== vexp[i]) begin bad++; $display("FAIL filt_step[%0d]: got tick=%b dac=%h want 1/%h", i, got, dac_b, vexp[i]); end
    end
    pause = 1'b1;
    @(negedge clk);
    // A still has the stale request for 0x0102 open; pause must not abort it.
    total++; if (req_a !== 1'b1 || raddr_a !== 18'h00102) begin bad++; $display("FAIL pause_keep_req: got req=%b addr=%h want 1/00102", req_a, raddr_a); end
    pulse_ack_a(8'h99);
    repeat (3) @(negedge clk);
    total++; if (req_a !== 1'b0 || valid_a !== 1'b0 || sin_a !== 8'h22) begin bad++; $display("FAIL pause_no_issue: got req=%b v=%b sin=%h want 0/0/22", req_a, valid_a, sin_a); end
    repeat (3 * DIV) @(negedge clk);
    total++; if (dac_b !== 16'h2500) begin bad++; $display("FAIL pause_hold_dac: got %h want 2500", dac_b); end
    pause = 1'b0;
    @(negedge clk);
    wait_req_a(got);
    total++; if (got !== 1'b1 || raddr_a !== 18'h00104) begin bad++; $display("FAIL unpause_req: got req=%b addr=%h want 1/00104", got, raddr_a); end
    wait_tick(got);
    total++; if (got !== 1'b1 || dac_b !== 16'h2BC0) begin bad++; $display("FAIL unpause_step: got tick=%b dac=%h want 1/2bc0", got, dac_b); end
  endtask

  task automatic test_reset_midreq;
    bit got;
    total++; if (req_a !== 1'b1) begin bad++; $display("FAIL rst_pre_req: got %b want 1", req_a); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (req_a !== 1'b0 || valid_a !== 1'b0 || dac_a !== 16'h0000 || dac_b !== 16'h0000) begin bad++; $display("FAIL rst_async: got req=%b v=%b dac=%h/%h want 0/0/0000/0000", req_a, valid_a, dac_a, dac_b); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wait_req_a(got);
    total++; if (got !== 1'b1 || raddr_a !== 18'h00000) begin bad++; $display("FAIL rst_refetch: got req=%b addr=%h want 1/00000", got, raddr_a); end
    pulse_ack_a(8'h6C);
    total++; if (sin_a !== 8'h6C || valid_a !== 1'b1) begin bad++; $display("FAIL rst_refetch_data: got sin=%h v=%b want 6c/1", sin_a, valid_a); end
  endtask

  initial begin
    test_reset;
    test_load_fetch;
    test_wrap;
    test_inc_midreq;
    test_dac_noshift;
    test_filter_pause;
    test_reset_midreq;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
